// File: rtl/alu_bist_ctrl.sv
// rtl/alu_bist_ctrl.sv - ALU built-in self-test controller: LFSR operands, opcode sweep, MISR signature
module alu_bist_ctrl #(
  parameter int          WIDTH         = 8,
  parameter int          SEL_W         = 4,
  parameter logic [15:0] LFSR_POLY     = 16'hB400,
  parameter logic [15:0] MISR_POLY     = 16'hB400,
  parameter logic [15:0] ZERO_SEED_SUB = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      seed,
  input  logic [15:0]      vec_count,
  input  logic [15:0]      expected_sig,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             carry_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      signature
);

  typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, DONE} state_t;

  state_t           state, state_nxt;
  logic [15:0]      lfsr, lfsr_nxt;
  logic [15:0]      misr, misr_nxt;
  logic [15:0]      remaining, remaining_nxt;
  logic [15:0]      exp_sig, exp_sig_nxt;
  logic [SEL_W-1:0] opcode, opcode_nxt;
  logic             busy_r, busy_nxt;
  logic             done_r, done_nxt;
  logic             pass_r, pass_nxt;

  logic [15:0]      data;
  logic [15:0]      misr_step;
  logic [15:0]      lfsr_step;

  assign data      = {{(15-WIDTH){1'b0}}, carry_out, alu_out};
  assign misr_step = ((misr >> 1) ^ (misr[0] ? MISR_POLY : 16'h0000)) ^ data;
  assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? LFSR_POLY : 16'h0000);

  always_comb begin
    state_nxt     = state;
    lfsr_nxt      = lfsr;
    misr_nxt      = misr;
    remaining_nxt = remaining;
    exp_sig_nxt   = exp_sig;
    opcode_nxt    = opcode;
    busy_nxt      = busy_r;
    done_nxt      = done_r;
    pass_nxt      = pass_r;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          lfsr_nxt      = (seed == 16'h0000) ? ZERO_SEED_SUB : seed;
          opcode_nxt    = '0;
          misr_nxt      = 16'hFFFF;
          remaining_nxt = vec_count;
          exp_sig_nxt   = expected_sig;
          if (vec_count == 16'h0000) begin
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            pass_nxt  = (expected_sig == 16'hFFFF);
          end else begin
            state_nxt = APPLY;
            busy_nxt  = 1'b1;
            done_nxt  = 1'b0;
            pass_nxt  = 1'b0;
          end
        end
      end
      APPLY: begin
        // operands settle through the ALU for one cycle before sampling
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        misr_nxt      = misr_step;
        lfsr_nxt      = lfsr_step;
        opcode_nxt    = opcode + SEL_W'(1);
        remaining_nxt = remaining - 16'd1;
        if (remaining == 16'd1) begin
          state_nxt = DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          pass_nxt  = (misr_step == exp_sig);
        end else begin
          state_nxt = APPLY;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lfsr      <= '0;
      misr      <= '0;
      remaining <= '0;
      exp_sig   <= '0;
      opcode    <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
    end else begin
      state     <= state_nxt;
      lfsr      <= lfsr_nxt;
      misr      <= misr_nxt;
      remaining <= remaining_nxt;
      exp_sig   <= exp_sig_nxt;
      opcode    <= opcode_nxt;
      busy_r    <= busy_nxt;
      done_r    <= done_nxt;
      pass_r    <= pass_nxt;
    end
  end

  assign alu_a     = lfsr[WIDTH-1:0];
  assign alu_b     = lfsr[WIDTH+7:8];
  assign alu_sel   = opcode;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign signature = misr;

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// tb/tb_alu_bist_ctrl.sv - directed self-checking bench for alu_bist_ctrl with a small ALU model
module tb_alu_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] seed;
  logic [15:0] vec_count;
  logic [15:0] expected_sig;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic [3:0]  alu_sel;
  logic        carry_out;
  logic        busy, done, pass;
  logic [15:0] signature;
  logic        fault_en;

  int checks = 0;
  int errors = 0;
  logic [3:0] sel_log [0:63];
  logic [7:0] a_log   [0:63];
  logic [7:0] b_log   [0:63];

  always #5 clk = ~clk;

  alu_bist_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .vec_count(vec_count),
    .expected_sig(expected_sig), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .carry_out(carry_out), .busy(busy), .done(done), .pass(pass),
    .signature(signature)
  );

  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    case (sel)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {1'b0, a} - {1'b0, b};
      4'd2:    return {1'b0, a & b};
      4'd3:    return {1'b0, a | b};
      4'd4:    return {1'b0, a ^ b};
      4'd5:    return {1'b0, ~a};
      4'd6:    return {a, 1'b0};
      4'd7:    return {1'b0, a >> 1};
      default: return {1'b0, a + {4'h0, sel}};
    endcase
  endfunction

  // fault_en corrupts bit 0 of every add result
  always_comb begin
    {carry_out, alu_out} = alu_f(alu_a, alu_b, alu_sel) ^ ((fault_en && alu_sel == 4'd0) ? 9'h001 : 9'h000);
  end

  function automatic logic [15:0] sig_model(input logic [15:0] s, input int n, input logic fault);
    logic [15:0] l, m;
    logic [3:0]  sel;
    logic [8:0]  r;
    l   = (s == 16'h0000) ? 16'hACE1 : s;
    m   = 16'hFFFF;
    sel = 4'd0;
    for (int i = 0; i < n; i++) begin
      r = alu_f(l[7:0], l[15:8], sel);
      if (fault && sel == 4'd0) r = r ^ 9'h001;
      m = ((m >> 1) ^ (m[0] ? 16'hB400 : 16'h0000)) ^ {7'h00, r};
      l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
      sel = sel + 4'd1;
    end
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] s, input logic [15:0] n, input logic [15:0] e);
    @(negedge clk);
    seed = s; vec_count = n; expected_sig = e; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // returns the index of the edge at which done was first seen (start edge = 0)
  task automatic run_until_done(input int pulse_at, output int k);
    k = 0;
    sel_log[0] = alu_sel; a_log[0] = alu_a; b_log[0] = alu_b;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
      start = (k == pulse_at);
      if (k < 64) begin
        sel_log[k] = alu_sel; a_log[k] = alu_a; b_log[k] = alu_b;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int k;
    logic [15:0] golden, faulty;
    rst_n = 1'b0; start = 1'b0; seed = '0; vec_count = '0; expected_sig = '0; fault_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_sig", signature, 16'h0000);
    check("rst_drive", {alu_a, alu_b, alu_sel}, 0);
    rst_n = 1'b1;

    do_start(16'hACE1, 16'd1, 16'hCA72);
    check("one_a", alu_a, 8'hE1);
    check("one_b", alu_b, 8'hAC);
    check("one_sel", alu_sel, 0);
    check("one_busy", busy, 1);
    run_until_done(-1, k);
    check("one_cycles", k, 2);
    check("one_sig", signature, 16'hCA72);
    check("one_pass", pass, 1);
    check("one_busy_end", busy, 0);

    do_start(16'h0000, 16'd1, 16'h1234);
    check("zs_a", alu_a, 8'hE1);
    check("zs_b", alu_b, 8'hAC);
    run_until_done(-1, k);
    check("zs_cycles", k, 2);
    check("zs_sig", signature, 16'hCA72);
    check("zs_pass", pass, 0);

    do_start(16'h1234, 16'd0, 16'hFFFF);
    check("v0_done", done, 1);
    check("v0_busy", busy, 0);
    check("v0_sig", signature, 16'hFFFF);
    check("v0_pass", pass, 1);
    do_start(16'h1234, 16'd0, 16'h0000);
    check("v0_nopass", pass, 0);
    check("v0_done2", done, 1);

    golden = sig_model(16'hACE1, 17, 1'b0);
    faulty = sig_model(16'hACE1, 17, 1'b1);
    do_start(16'hACE1, 16'd17, golden);
    check("v17_done_clr", done, 0);
    run_until_done(-1, k);
    check("v17_cycles", k, 34);
    check("v17_sel0", sel_log[0], 0);
    check("v17_vec2_a", a_log[2], 8'h70);
    check("v17_vec2_b", b_log[2], 8'hE2);
    check("v17_vec2_sel", sel_log[2], 1);
    check("v17_sel15", sel_log[30], 15);
    check("v17_wrap", sel_log[32], 0);
    check("v17_sig", signature, golden);
    check("v17_pass", pass, 1);

    fault_en = 1'b1;
    do_start(16'hACE1, 16'd17, golden);
    run_until_done(5, k);
    check("flt_cycles", k, 34);
    check("flt_sig_differs", signature != golden, 1);
    check("flt_sig", signature, faulty);
    check("flt_pass", pass, 0);
    fault_en = 1'b0;

    do_start(16'hACE1, 16'd17, golden);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_sig", signature, 16'h0000);
    check("mid_drive", {alu_a, alu_b, alu_sel}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_start(16'hACE1, 16'd1, 16'hCA72);
    run_until_done(-1, k);
    check("post_cycles", k, 2);
    check("post_sig", signature, 16'hCA72);
    check("post_pass", pass, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
